// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the I-cache request, buffers a
// response that the stalled IF/ID buffer cannot take, and drains redirects.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        icache_read,
  output logic [15:0] icache_address,
  input  logic [15:0] icache_rdata,
  input  logic        icache_resp,
  output logic        if_load,
  output logic        if_valid,
  output logic [15:0] if_instruction,
  output logic [15:0] if_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] hold_inst, hold_inst_n;
  logic [15:0] hold_pc, hold_pc_n;
  logic [15:0] tgt_pc, tgt_pc_n;
  logic [15:0] pc_inc;

  assign pc_inc = pc + 16'd2;

  // State and fetch registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hold_inst <= NOP_WORD;
      hold_pc   <= 16'h0000;
      tgt_pc    <= 16'h0000;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_inst <= hold_inst_n;
      hold_pc   <= hold_pc_n;
      tgt_pc    <= tgt_pc_n;
    end
  end

  // Next-state and output decode; redirect overrides the delivered word
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    hold_inst_n    = hold_inst;
    hold_pc_n      = hold_pc;
    tgt_pc_n       = tgt_pc;
    icache_read    = 1'b0;
    icache_address = pc;
    if_load        = 1'b0;
    if_valid       = 1'b0;
    if_instruction = NOP_WORD;
    if_pc          = 16'h0000;
    if (reset_n) begin
      if (redirect) begin
        if_pc   = redirect_pc;
        if_load = !stall;
      end
      unique case (state)
        FETCH: begin
          icache_read = 1'b1;
          if (redirect) begin
            if (icache_resp) begin
              pc_n = redirect_pc;
            end else begin
              tgt_pc_n = redirect_pc;
              state_n  = DRAIN;
            end
          end else if (icache_resp) begin
            if_valid       = 1'b1;
            if_instruction = icache_rdata;
            if_pc          = pc_inc;
            if_load        = !stall;
            pc_n           = pc_inc;
            if (stall) begin
              hold_inst_n = icache_rdata;
              hold_pc_n   = pc_inc;
              state_n     = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_n    = redirect_pc;
            state_n = FETCH;
          end else begin
            if_valid       = 1'b1;
            if_instruction = hold_inst;
            if_pc          = hold_pc;
            if_load        = !stall;
            if (!stall) state_n = FETCH;
          end
        end
        DRAIN: begin
          icache_read = 1'b1;
          if (redirect) begin
            if (icache_resp) begin
              pc_n    = redirect_pc;
              state_n = FETCH;
            end else begin
              tgt_pc_n = redirect_pc;
            end
          end else if (icache_resp) begin
            pc_n    = tgt_pc;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// all checked against a transaction-level model of the fetch unit.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect;
  logic [15:0] redirect_pc;
  logic        icache_read;
  logic [15:0] icache_address;
  logic [15:0] icache_rdata;
  logic        icache_resp;
  logic        if_load, if_valid;
  logic [15:0] if_instruction, if_pc;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .icache_read(icache_read),
    .icache_address(icache_address),
    .icache_rdata(icache_rdata),
    .icache_resp(icache_resp),
    .if_load(if_load),
    .if_valid(if_valid),
    .if_instruction(if_instruction),
    .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  // model: next fetch address, a buffered word, a wrong-path request
  logic [15:0] m_pc, m_hinst, m_hpc, m_tgt;
  bit          m_holding, m_wrong;
  logic [15:0] x_pc, x_hinst, x_hpc, x_tgt;
  bit          x_holding, x_wrong;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit st, input bit rd,
                       input logic [15:0] rpc, input bit rsp);
    bit          e_read, e_load, e_valid, chk_valid, chk_data;
    logic [15:0] e_inst, e_ifpc, data;
    e_read      = rst && !m_holding;
    data        = m_pc ^ 16'hA5A5;
    reset_n     = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    icache_resp = rsp && e_read;
    icache_rdata = icache_resp ? data : 16'($urandom);
    x_pc = m_pc; x_hinst = m_hinst; x_hpc = m_hpc; x_tgt = m_tgt;
    x_holding = m_holding; x_wrong = m_wrong;
    e_load = 0; e_valid = 0; e_inst = 16'h0000; e_ifpc = 16'h0000;
    chk_valid = 1; chk_data = 1;
    if (!rst) begin
      x_pc = 16'h0000; x_hinst = 16'h0000; x_hpc = 16'h0000;
      x_tgt = 16'h0000; x_holding = 0; x_wrong = 0;
    end else if (rd) begin
      e_load = !st;
      e_ifpc = rpc;
      if (m_holding) begin
        x_holding = 0; x_pc = rpc;
      end else if (icache_resp) begin
        x_wrong = 0; x_pc = rpc;
      end else begin
        x_wrong = 1; x_tgt = rpc;
      end
    end else if (m_holding) begin
      e_valid = 1; e_inst = m_hinst; e_ifpc = m_hpc;
      e_load = !st;
      if (!st) x_holding = 0;
    end else if (m_wrong) begin
      chk_data = 0;
      if (icache_resp) begin
        x_wrong = 0; x_pc = m_tgt;
      end
    end else if (icache_resp) begin
      e_inst = data; e_ifpc = m_pc + 16'd2; e_valid = 1;
      e_load = !st;
      x_pc = m_pc + 16'd2;
      if (st) begin
        chk_valid = 0;
        x_holding = 1; x_hinst = data; x_hpc = m_pc + 16'd2;
      end
    end else begin
      chk_data = 0;
    end
    #1;
    check("icache_read", 16'(icache_read), 16'(e_read));
    if (e_read) check("icache_address", icache_address, m_pc);
    check("if_load", 16'(if_load), 16'(e_load));
    if (chk_valid) check("if_valid", 16'(if_valid), 16'(e_valid));
    if (chk_data) begin
      check("if_instruction", if_instruction, e_inst);
      check("if_pc", if_pc, e_ifpc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_pc = x_pc; m_hinst = x_hinst; m_hpc = x_hpc; m_tgt = x_tgt;
    m_holding = x_holding; m_wrong = x_wrong;
    #1;
  endtask

  initial begin
    m_pc = 0; m_hinst = 0; m_hpc = 0; m_tgt = 0;
    m_holding = 0; m_wrong = 0;
    @(posedge clk); #1;
    // reset, then back-to-back single-cycle responses
    drive(0, 0, 0, 16'h0, 0);
    check("rst_read", 16'(icache_read), 16'h0);
    tick();
    drive(1, 0, 0, 16'h0, 1);
    check("seq0_pc", if_pc, 16'h0002);
    check("seq0_inst", if_instruction, 16'hA5A5);
    tick();
    drive(1, 0, 0, 16'h0, 1);
    check("seq1_pc", if_pc, 16'h0004);
    check("seq1_inst", if_instruction, 16'hA5A7);
    tick();
    drive(1, 0, 0, 16'h0, 1);
    check("seq2_pc", if_pc, 16'h0006);
    check("seq2_inst", if_instruction, 16'hA5A1);
    tick();
    // stalled response at 0x0010 buffered for three cycles
    drive(1, 0, 1, 16'h0010, 1); tick();
    drive(1, 1, 0, 16'h0, 1);
    check("stall_load", 16'(if_load), 16'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'h0, 0);
      check("hold_read", 16'(icache_read), 16'h0);
      check("hold_load", 16'(if_load), 16'h0);
      tick();
    end
    drive(1, 0, 0, 16'h0, 0);
    check("hold_release", 16'(if_load), 16'h1);
    check("hold_pc", if_pc, 16'h0012);
    tick();
    drive(1, 0, 0, 16'h0, 0);
    check("after_hold_addr", icache_address, 16'h0012);
    tick();
    // redirect while a request at 0x0020 is pending
    drive(1, 0, 1, 16'h0020, 1); tick();
    drive(1, 0, 1, 16'h0100, 0); tick();
    drive(1, 0, 0, 16'h0, 0);
    check("drain_addr", icache_address, 16'h0020);
    tick();
    drive(1, 0, 0, 16'h0, 1);
    check("drain_drop", 16'(if_load), 16'h0);
    tick();
    drive(1, 0, 0, 16'h0, 0);
    check("drain_next", icache_address, 16'h0100);
    tick();
    // redirect coinciding with a response
    drive(1, 0, 1, 16'h0200, 1);
    check("redir_valid", 16'(if_valid), 16'h0);
    check("redir_inst", if_instruction, 16'h0000);
    tick();
    drive(1, 0, 0, 16'h0, 0);
    check("redir_addr", icache_address, 16'h0200);
    tick();
    // wrap from 0xFFFE
    drive(1, 0, 1, 16'hFFFE, 1); tick();
    drive(1, 0, 0, 16'h0, 1);
    check("wrap_ifpc", if_pc, 16'h0000);
    tick();
    drive(1, 0, 0, 16'h0, 0);
    check("wrap_addr", icache_address, 16'h0000);
    tick();
    // reset for one cycle while holding
    drive(1, 1, 0, 16'h0, 1); tick();
    drive(0, 0, 0, 16'h0, 0);
    check("rst_hold_load", 16'(if_load), 16'h0);
    tick();
    drive(1, 0, 0, 16'h0, 0);
    check("rst_hold_read", 16'(icache_read), 16'h1);
    check("rst_hold_addr", icache_address, 16'h0000);
    check("rst_hold_valid", 16'(if_valid), 16'h0);
    tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0,
            16'($urandom_range(0, 32767) * 2),
            $urandom_range(0, 1) == 1);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 16'h0000: bubble instruction, BR with nzp=000.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port reset_n, input, 1: synchronous active-low reset, sampled on rising clk.
REQ-005 Port stall, input, 1: IF/ID buffer cannot accept this cycle.
REQ-006 Port redirect, input, 1: taken branch/jump resolved downstream.
REQ-007 Port redirect_pc, input, 16: target address, valid while redirect=1.
REQ-008 Port icache_read, output, 1: I-cache read request, level-held until icache_resp.
REQ-009 Port icache_address, output, 16: request address, stable while a request is pending.
REQ-010 Port icache_rdata, input, 16: instruction word, valid when icache_resp=1.
REQ-011 Port icache_resp, input, 1: single-cycle completion pulse.
REQ-012 Port if_load, output, 1: load strobe to the IF/ID buffer.
REQ-013 Port if_valid, output, 1: if_instruction is a real fetched instruction, not a bubble.
REQ-014 Port if_instruction, output, 16: instruction to the IF/ID buffer.
REQ-015 Port if_pc, output, 16: fetch address + 2, to the IF/ID buffer.

Function
REQ-016 States FETCH, HOLD and DRAIN shall be implemented, plus registers pc, hold_inst, hold_pc and tgt_pc.
REQ-017 In FETCH: icache_read=1 and icache_address=pc.
REQ-018 FETCH, resp=1, redirect=0, stall=0: if_load=1, if_valid=1, if_instruction=icache_rdata, if_pc=pc+2 (mod 2^16); pc<=pc+2; remain in FETCH.
REQ-019 FETCH, resp=1, redirect=0, stall=1: if_load=0; hold_inst<=icache_rdata, hold_pc<=pc+2, pc<=pc+2; next state HOLD.
REQ-020 FETCH, resp=0, redirect=0: if_load=0, if_valid=0; hold all registers regardless of stall.
REQ-021 In HOLD: icache_read=0, if_valid=1, if_instruction=hold_inst, if_pc=hold_pc, if_load=!stall; next state FETCH when stall=0.
REQ-022 In DRAIN: icache_read=1 with icache_address=pc (the old, wrong-path address), if_valid=0, if_load=0; the returned data shall be discarded.
REQ-023 DRAIN, resp=1: pc<=tgt_pc; next state FETCH.
REQ-024 Redirect in any state: if_valid=0, if_instruction=NOP_WORD, if_pc=redirect_pc, if_load=!stall.
REQ-025 Redirect in FETCH, resp=0: tgt_pc<=redirect_pc; next state DRAIN; icache_address shall not change mid-request.
REQ-026 Redirect in FETCH, resp=1: discard data; pc<=redirect_pc; remain in FETCH.
REQ-027 Redirect in HOLD: discard hold contents; pc<=redirect_pc; next state FETCH.
REQ-028 Redirect in DRAIN, resp=0: tgt_pc<=redirect_pc, so the latest redirect wins; remain in DRAIN.
REQ-029 Redirect in DRAIN, resp=1: pc<=redirect_pc; next state FETCH.
REQ-030 Latency: with no stall and a 1-cycle cache, one instruction per response; if_load is combinational from resp, stall and redirect.
REQ-031 PC arithmetic is 16-bit unsigned and wraps from 16'hFFFE to 16'h0000.

Reset
REQ-032 While reset_n=0, at the clock edge: state<=FETCH, pc<=RESET_PC, hold_inst<=NOP_WORD, hold_pc<=0, tgt_pc<=0.
REQ-033 During any reset cycle: icache_read=0, if_load=0, if_valid=0, if_instruction=NOP_WORD, if_pc=0; the first request issues in the first cycle after reset_n rises.
REQ-034 Reset asserted mid-request or in HOLD/DRAIN shall abandon the transaction; a stale icache_resp in the first post-reset cycle is permitted only when icache_read=1 and is consumed as a normal response.

Verification
REQ-035 Reset, RESET_PC=0, resp every cycle with rdata=addr^16'hA5A5, no stall -> if_load each cycle; if_pc sequence 2,4,6; if_instruction A5A5, A5A7, A5A1.
REQ-036 Response at pc=16'h0010 with stall=1 for 3 cycles -> HOLD, icache_read=0, if_load=0 for 3 cycles; then if_load=1, if_pc=16'h0012; next request at 16'h0012.
REQ-037 Redirect to 16'h0100 while a request at 16'h0020 is pending -> DRAIN, icache_address stays 16'h0020; on resp the data is dropped; next request at 16'h0100.
REQ-038 Redirect to 16'h0200 coinciding with a response -> data dropped, if_valid=0, if_instruction=16'h0000; next cycle icache_address=16'h0200.
REQ-039 pc=16'hFFFE response, no stall -> if_pc=16'h0000; next request at 16'h0000.
REQ-040 reset_n=0 for one cycle while in HOLD -> if_load=0 during the reset cycle; next cycle FETCH at RESET_PC with hold data not delivered.
